// File: rtl/q2par.sv
// Shared constants and types for the q2 multiply-add datapath and its
// downstream frame accumulator.
package q2par;

    localparam int Width = 8;
    localparam int NSamp = 4;
    localparam int CNT_W = $clog2(NSamp);
    localparam int SUM_W = 2 * Width + CNT_W;

    typedef logic [2*Width-1:0] sample_t;
    typedef logic [SUM_W-1:0]   sum_t;

endpackage

// File: rtl/q2_accum.sv
// Frame accumulator: sums NSAMP consecutive q2 DATA_OUT samples and offers
// each frame sum on a registered valid/ready output.
module q2_accum
    import q2par::*;
#(
    parameter  int WIDTH = Width,
    parameter  int NSAMP = NSamp,
    localparam int CntW  = $clog2(NSAMP),
    localparam int SumW  = 2 * WIDTH + CntW
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clr,
    input  logic [2*WIDTH-1:0]   in_data,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [SumW-1:0]      sum_out,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [7:0]           frame_cnt
);

    logic [SumW-1:0] acc_q;
    logic [SumW-1:0] acc_d;
    logic [SumW-1:0] sum_q;
    logic [CntW-1:0] cnt_q;
    logic            outValid_q;
    logic [7:0]      frameCnt_q;
    logic            lastSample;
    logic            accept;

    assign lastSample = (cnt_q == CntW'(NSAMP - 1));

    // Stall only when this sample would finish a frame whose predecessor is
    // still waiting; the in-flight sum must never be overwritten.
    assign in_ready = !clr && !(outValid_q && !out_ready && lastSample);
    assign accept   = in_valid && in_ready;
    assign acc_d    = acc_q + SumW'(in_data);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q      <= '0;
            cnt_q      <= '0;
            sum_q      <= '0;
            outValid_q <= 1'b0;
            frameCnt_q <= 8'd0;
        end else if (clr) begin
            acc_q      <= '0;
            cnt_q      <= '0;
            outValid_q <= 1'b0;
        end else begin
            if (outValid_q && out_ready) begin
                outValid_q <= 1'b0;
            end
            // A completing frame wins over the consume above, so back-to-back
            // frames keep out_valid high without a bubble.
            if (accept) begin
                if (lastSample) begin
                    sum_q      <= acc_d;
                    outValid_q <= 1'b1;
                    acc_q      <= '0;
                    cnt_q      <= '0;
                    frameCnt_q <= frameCnt_q + 8'd1;
                end else begin
                    acc_q <= acc_d;
                    cnt_q <= cnt_q + CntW'(1);
                end
            end
        end
    end

    assign sum_out   = sum_q;
    assign out_valid = outValid_q;
    assign frame_cnt = frameCnt_q;

endmodule
